// File: rtl/cdc_src_arbiter.sv
// cdc_src_arbiter: round-robin merge of NumIn valid/ready requesters onto one
// registered {tag, payload} stream, plus the drain/clear/ack sequencer for the CDC.
module cdc_src_arbiter #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter int ClrCycles = 4,
    localparam int IdxWidth = $clog2(NumIn)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumIn*DataWidth-1:0]    in_data_i,
    input  logic [NumIn-1:0]              in_valid_i,
    output logic [NumIn-1:0]              in_ready_o,
    output logic [IdxWidth+DataWidth-1:0] out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          out_clr_o,
    input  logic                          clr_req_i,
    output logic                          clr_ack_o,
    output logic                          busy_o
);

    localparam int CntWidth = (ClrCycles > 1) ? $clog2(ClrCycles) : 1;

    typedef enum logic [1:0] {
        ST_ARB,
        ST_DRAIN,
        ST_CLEAR,
        ST_ACK
    } state_e;

    state_e                        state_q, state_d;
    logic [CntWidth-1:0]           cnt_q, cnt_d;
    logic                          full_q, full_d;
    logic [IdxWidth+DataWidth-1:0] data_q, data_d;
    logic [IdxWidth-1:0]           ptr_q, ptr_d;

    logic                          win_found;
    logic [IdxWidth-1:0]           win_idx;
    logic [IdxWidth-1:0]           ptr_nxt;
    logic                          pop;
    logic                          can_acc;
    logic                          xfer;

    // Index arithmetic modulo NumIn, which need not be a power of two.
    function automatic logic [IdxWidth-1:0] wrap_add(
        input logic [IdxWidth-1:0] base,
        input int                  off
    );
        int s;
        s = int'(base) + off;
        if (s >= NumIn) s = s - NumIn;
        return IdxWidth'(s);
    endfunction

    assign pop     = full_q & out_ready_i;
    assign can_acc = (state_q == ST_ARB) & ~clr_req_i & ~rst_i & (~full_q | pop);
    assign xfer    = can_acc & win_found;
    assign ptr_nxt = wrap_add(win_idx, 1);

    // Pick the first valid requester starting at the round-robin pointer.
    always_comb begin
        logic [IdxWidth-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NumIn - 1; k >= 0; k--) begin
            cand = wrap_add(ptr_q, k);
            if (in_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // One-hot ready to the winner only when it can actually transfer.
    always_comb begin
        in_ready_o = '0;
        if (xfer) in_ready_o[win_idx] = 1'b1;
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        ptr_d  = ptr_q;
        if (pop) full_d = 1'b0;
        if (xfer) begin
            full_d = 1'b1;
            data_d = {win_idx, in_data_i[int'(win_idx)*DataWidth +: DataWidth]};
            ptr_d  = ptr_nxt;
        end
        if (state_q == ST_CLEAR) ptr_d = '0;
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
            ptr_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            ptr_q  <= ptr_d;
        end
    end

    // FSM state and clear-duration counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ARB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear sequence: drain the register, hold clear, then 4-phase ack.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_ARB: begin
                if (clr_req_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (~full_q | pop) begin
                    state_d = ST_CLEAR;
                    cnt_d   = CntWidth'(ClrCycles - 1);
                end
            end
            ST_CLEAR: begin
                if (cnt_q == '0) state_d = ST_ACK;
                else             cnt_d   = cnt_q - CntWidth'(1);
            end
            ST_ACK: begin
                if (~clr_req_i) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Status and sideband outputs decoded from state.
    always_comb begin
        out_valid_o = full_q;
        out_data_o  = data_q;
        out_clr_o   = (state_q == ST_CLEAR);
        clr_ack_o   = (state_q == ST_ACK);
        busy_o      = full_q | (state_q != ST_ARB);
    end

endmodule

// File: tb/tb_cdc_src_arbiter.sv
// tb_cdc_src_arbiter: directed vectors for arbitration, backpressure,
// clear sequencing and reset during clear.
module tb_cdc_src_arbiter;

    localparam int NumIn     = 4;
    localparam int DataWidth = 32;
    localparam int IdxWidth  = 2;

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic [NumIn*DataWidth-1:0]    in_data_i;
    logic [NumIn-1:0]              in_valid_i;
    logic [NumIn-1:0]              in_ready_o;
    logic [IdxWidth+DataWidth-1:0] out_data_o;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic                          out_clr_o;
    logic                          clr_req_i;
    logic                          clr_ack_o;
    logic                          busy_o;

    always #5 clk_i = ~clk_i;

    cdc_src_arbiter #(
        .NumIn    (NumIn),
        .DataWidth(DataWidth),
        .ClrCycles(4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_data_o (out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_clr_o  (out_clr_o),
        .clr_req_i  (clr_req_i),
        .clr_ack_o  (clr_ack_o),
        .busy_o     (busy_o)
    );

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       rdy;
        logic       clr;
        logic [3:0] ir;
        logic       ov;
        logic [1:0] tag;
        logic       oclr;
        logic       ack;
        logic       busy;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    function automatic logic [31:0] payload(input logic [1:0] i);
        return 32'hA5C30000 + 32'(i);
    endfunction

    function automatic vec_t mk(
        input logic rst, input logic [3:0] v, input logic rdy, input logic clr,
        input logic [3:0] ir, input logic ov, input logic [1:0] tag,
        input logic oclr, input logic ack, input logic busy
    );
        vec_t t;
        t.rst = rst; t.v = v; t.rdy = rdy; t.clr = clr;
        t.ir = ir; t.ov = ov; t.tag = tag;
        t.oclr = oclr; t.ack = ack; t.busy = busy;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then advance.
    task automatic run(input vec_t t, input string nm);
        logic [33:0] exp_data;
        rst_i       = t.rst;
        in_valid_i  = t.v;
        out_ready_i = t.rdy;
        clr_req_i   = t.clr;
        #1;
        chk({nm, " in_ready"}, 64'(in_ready_o), 64'(t.ir));
        chk({nm, " out_valid"}, 64'(out_valid_o), 64'(t.ov));
        chk({nm, " out_clr"}, 64'(out_clr_o), 64'(t.oclr));
        chk({nm, " clr_ack"}, 64'(clr_ack_o), 64'(t.ack));
        chk({nm, " busy"}, 64'(busy_o), 64'(t.busy));
        if (t.ov) begin
            exp_data = {t.tag, payload(t.tag)};
            chk({nm, " out_data"}, 64'(out_data_o), 64'(exp_data));
        end
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        for (int i = 0; i < NumIn; i++)
            in_data_i[i*DataWidth +: DataWidth] = payload(2'(i));

        // reset, all requesters valid
        tbl.push_back(mk(1, 4'hF, 1, 0, 4'b0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 1, 0, 4'b0000, 0, 0, 0, 0, 0));
        // fairness: tags 0,1,2,3,0,1 back to back
        tbl.push_back(mk(0, 4'hF, 1, 0, 4'b0001, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hF, 1, 0, 4'b0010, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 4'hF, 1, 0, 4'b0100, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 4'hF, 1, 0, 4'b1000, 1, 2, 0, 0, 1));
        tbl.push_back(mk(0, 4'hF, 1, 0, 4'b0001, 1, 3, 0, 0, 1));
        tbl.push_back(mk(0, 4'hF, 1, 0, 4'b0010, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 4'hF, 1, 0, 4'b0100, 1, 1, 0, 0, 1));
        // backpressure 10 cycles, data stable
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 4'hF, 0, 0, 4'b0000, 1, 2, 0, 0, 1));
        // release: pop and accept same cycle
        tbl.push_back(mk(0, 4'hF, 1, 0, 4'b1000, 1, 2, 0, 0, 1));
        // sparse: only req 2 after req 3 served, then ptr must be 3
        tbl.push_back(mk(0, 4'b0100, 1, 0, 4'b0100, 1, 3, 0, 0, 1));
        tbl.push_back(mk(0, 4'b1100, 1, 0, 4'b1000, 1, 2, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0101, 1, 0, 4'b0001, 1, 3, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0, 0));

        rst_i       = 1'b1;
        in_valid_i  = 4'hF;
        out_ready_i = 1'b1;
        clr_req_i   = 1'b0;
        @(posedge clk_i);
        #2;

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // clear with full register under backpressure (ptr is 1 here)
        run(mk(0, 4'b0010, 0, 0, 4'b0010, 0, 0, 0, 0, 0), "clr_fill");
        for (int i = 0; i < 5; i++)
            run(mk(0, 4'hF, 0, 1, 4'b0000, 1, 1, 0, 0, 1), $sformatf("clr_drain%0d", i));
        run(mk(0, 4'hF, 1, 1, 4'b0000, 1, 1, 0, 0, 1), "clr_pop");
        for (int i = 0; i < 4; i++)
            run(mk(0, 4'hF, 1, 1, 4'b0000, 0, 0, 1, 0, 1), $sformatf("clr_hold%0d", i));
        for (int i = 0; i < 3; i++)
            run(mk(0, 4'hF, 1, 1, 4'b0000, 0, 0, 0, 1, 1), $sformatf("clr_ack%0d", i));
        run(mk(0, 4'b0110, 1, 0, 4'b0000, 0, 0, 0, 1, 1), "clr_reqlow");
        run(mk(0, 4'b0110, 1, 0, 4'b0010, 0, 0, 0, 0, 0), "clr_firstgnt");
        run(mk(0, 4'b0000, 1, 0, 4'b0000, 1, 1, 0, 0, 1), "clr_firstout");

        // reset during the second clear cycle
        run(mk(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 0, 0, 0), "rst_req");
        run(mk(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 0, 0, 1), "rst_drain");
        run(mk(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 1, 0, 1), "rst_clr1");
        run(mk(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 1, 0, 1), "rst_clr2");
        run(mk(0, 4'b0001, 1, 0, 4'b0001, 0, 0, 0, 0, 0), "rst_after");
        run(mk(0, 4'b0000, 1, 0, 4'b0000, 1, 0, 0, 0, 1), "rst_out");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
